pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/pipe_slot.sv | 76 +++++++
 rtl/pipe_stage_skid.sv | 214 +++++++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the skid-buffered pipeline stage:
//   - default payload / counter widths
//   - occupancy state enum (EMPTY / HALF / FULL)
//   - main-slot load source selector
// -----------------------------------------------------------------------------
package pipe_pkg;

  // Default widths: datapath payload, control payload, bubble counter.
  localparam int DATA_W_DEF = 160;
  localparam int CTRL_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  // Occupancy of the stage: EMPTY = no slot valid, HALF = main valid,
  // FULL = main and skid valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Where the main slot takes its new contents from when it loads.
  typedef enum logic {
    SRC_IN   = 1'b0,
    SRC_SKID = 1'b1
  } main_src_e;

endpackage : pipe_pkg

// File: rtl/pipe_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
// One storage slot of the pipeline stage: a valid bit plus a datapath and a
// control payload register. Clear dominates load, and a cleared slot holds
// all-zero data and control so it reads as a harmless bubble.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset (clears the slot)
//   clr_i   in   clear the slot (dominant over ld_i)
//   ld_i    in   load data_i/ctrl_i and mark the slot valid
//   data_i  in   datapath payload to load
//   ctrl_i  in   control payload to load
//   valid_o out  slot holds a live entry
//   data_o  out  stored datapath payload
//   ctrl_o  out  stored control payload
// -----------------------------------------------------------------------------
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              ld_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

  // Next-state: clear wins over load, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (clr_i) begin
      valid_d = 1'b0;
      data_d  = {DATA_W{1'b0}};
      ctrl_d  = {CTRL_W{1'b0}};
    end else if (ld_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      ctrl_d  = ctrl_i;
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
      ctrl_d  = ctrl_q;
    end
  end

  // Slot registers with synchronous reset to the empty/bubble value.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= {DATA_W{1'b0}};
      ctrl_q  <= {CTRL_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule : pipe_slot

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
// Two-entry skid-buffered pipeline register. The main slot drives the
// outputs; the skid slot catches the one instruction that arrives in the
// cycle the downstream stalls, so in_ready depends only on registered state
// (never combinationally on out_ready). Full throughput, one-cycle latency.
// flush empties both slots; rst overrides everything. A saturating counter
// records cycles in which no instruction is presented downstream.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   flush       in   discard all held entries and the input of this cycle
//   in_valid    in   upstream presents an instruction
//   in_ready    out  stage accepts the instruction this cycle
//   in_data     in   datapath payload (DATA_W)
//   in_ctrl     in   control payload (CTRL_W)
//   out_valid   out  out_data/out_ctrl hold a live instruction
//   out_ready   in   downstream consumes the instruction this cycle
//   out_data    out  registered datapath payload
//   out_ctrl    out  registered control payload, zero when out_valid=0
//   bubble_cnt  out  saturating count of cycles with out_valid=0
// -----------------------------------------------------------------------------
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;

  // Slot control produced by the output process.
  logic              main_ld_s, main_clr_s;
  logic              skid_ld_s, skid_clr_s;
  main_src_e         main_src_s;
  logic [DATA_W-1:0] main_din_s;
  logic [CTRL_W-1:0] main_cin_s;

  // Slot contents.
  logic              main_valid_s, skid_valid_s;
  logic [DATA_W-1:0] main_data_s,  skid_data_s;
  logic [CTRL_W-1:0] main_ctrl_s,  skid_ctrl_s;

  logic              in_xfer_s, out_xfer_s;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Ready only while the skid slot is free; rst masks it for the reset cycle.
  assign in_ready   = ~skid_valid_s & ~rst;
  assign in_xfer_s  = in_valid & in_ready;
  assign out_xfer_s = main_valid_s & out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush beats every transfer.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer_s) state_d = ST_HALF;
          else           state_d = ST_EMPTY;
        end
        ST_HALF: begin
          if (in_xfer_s && !out_xfer_s)      state_d = ST_FULL;
          else if (!in_xfer_s && out_xfer_s) state_d = ST_EMPTY;
          else                               state_d = ST_HALF;
        end
        ST_FULL: begin
          if (out_xfer_s) state_d = ST_HALF;
          else            state_d = ST_FULL;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Output logic: slot load/clear commands for the current state and transfers.
  always_comb begin
    main_ld_s  = 1'b0;
    main_clr_s = 1'b0;
    skid_ld_s  = 1'b0;
    skid_clr_s = 1'b0;
    main_src_s = SRC_IN;
    if (flush) begin
      main_clr_s = 1'b1;
      skid_clr_s = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          main_ld_s = in_xfer_s;
        end
        ST_HALF: begin
          if (in_xfer_s && out_xfer_s) begin
            main_ld_s = 1'b1;
          end else if (in_xfer_s) begin
            // Downstream stalled: park the newcomer behind main.
            skid_ld_s = 1'b1;
          end else if (out_xfer_s) begin
            main_clr_s = 1'b1;
          end else begin
            main_ld_s = 1'b0;
          end
        end
        ST_FULL: begin
          if (out_xfer_s) begin
            main_ld_s  = 1'b1;
            main_src_s = SRC_SKID;
            skid_clr_s = 1'b1;
          end else begin
            main_ld_s = 1'b0;
          end
        end
        default: begin
          main_clr_s = 1'b1;
          skid_clr_s = 1'b1;
        end
      endcase
    end
  end

  // Main-slot input mux: fresh input, or promote the skid entry.
  always_comb begin
    if (main_src_s == SRC_SKID) begin
      main_din_s = skid_data_s;
      main_cin_s = skid_ctrl_s;
    end else begin
      main_din_s = in_data;
      main_cin_s = in_ctrl;
    end
  end

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (main_clr_s),
    .ld_i    (main_ld_s),
    .data_i  (main_din_s),
    .ctrl_i  (main_cin_s),
    .valid_o (main_valid_s),
    .data_o  (main_data_s),
    .ctrl_o  (main_ctrl_s)
  );

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (skid_clr_s),
    .ld_i    (skid_ld_s),
    .data_i  (in_data),
    .ctrl_i  (in_ctrl),
    .valid_o (skid_valid_s),
    .data_o  (skid_data_s),
    .ctrl_o  (skid_ctrl_s)
  );

  // Bubble counter next value: count idle output cycles, stick at the top.
  always_comb begin
    if (!main_valid_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Bubble counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Outputs read zero throughout a reset cycle, so nothing is emitted while
  // rst is high even if the slot registers still hold an entry.
  assign out_valid  = main_valid_s & ~rst;
  assign out_data   = rst ? {DATA_W{1'b0}} : main_data_s;
  assign out_ctrl   = rst ? {CTRL_W{1'b0}} : main_ctrl_s;
  assign bubble_cnt = rst ? {CNT_W{1'b0}}  : cnt_q;

endmodule : pipe_stage_skid

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
// Queue-based reference model of a two-deep in-order buffer, compared against
// the DUT every cycle, plus directed sequences with literal expectations.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;

  localparam int DW = 160;
  localparam int CW = 8;
  localparam int NW = 4;
  localparam int CNT_TOP = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [NW-1:0] bubble_cnt;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W (DW),
    .CTRL_W (CW),
    .CNT_W  (NW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_ctrl    (in_ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ctrl   (out_ctrl),
    .bubble_cnt (bubble_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an in-order queue of at most two entries.
  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t mq[$];
  int   mcnt = 0;
  bit   model_on = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        mcnt = 0;
        model_on = 1'b1;
      end else begin
        bit pop;
        bit push;
        if (mq.size() == 0 && mcnt < CNT_TOP) mcnt++;
        if (flush) begin
          mq.delete();
        end else begin
          pop  = (mq.size() > 0) && out_ready;
          push = in_valid && (mq.size() < 2);
          if (pop) void'(mq.pop_front());
          if (push) mq.push_back('{d: in_data, c: in_ctrl});
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_on) begin
        logic          ev;
        logic [DW-1:0] ed;
        logic [CW-1:0] ec;
        ev = !rst && (mq.size() > 0);
        ed = ev ? mq[0].d : '0;
        ec = ev ? mq[0].c : '0;
        chk("m_out_valid", DW'(out_valid), DW'(ev));
        chk("m_out_data", out_data, ed);
        chk("m_out_ctrl", DW'(out_ctrl), DW'(ec));
        chk("m_in_ready", DW'(in_ready), DW'(!rst && (mq.size() < 2)));
        chk("m_bubble_cnt", DW'(bubble_cnt), rst ? '0 : DW'(mcnt));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
  endtask

  initial begin
    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_in_ready", DW'(in_ready), '0);
    chk("rst_bubble", DW'(bubble_cnt), '0);

    // Single transfer 0xA5 with out_ready high.
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, DW'(8'hA5), 8'h01);
    #1;
    chk("first_in_ready", DW'(in_ready), DW'(1));
    tick();
    chk("a5_out_valid", DW'(out_valid), DW'(1));
    chk("a5_out_data", out_data, DW'(8'hA5));
    chk("a5_in_ready", DW'(in_ready), DW'(1));
    chk("a5_bubble", DW'(bubble_cnt), DW'(1));
    drive(1'b0, '0, '0);
    tick();
    chk("a5_drained", DW'(out_valid), '0);

    // Stream 1,2,3 with a stall from the second cycle.
    drive(1'b1, DW'(1), 8'h11);
    tick();
    out_ready = 1'b0;
    drive(1'b1, DW'(2), 8'h12);
    tick();
    drive(1'b1, DW'(3), 8'h13);
    tick();
    chk("full_in_ready", DW'(in_ready), '0);
    chk("full_out_data", out_data, DW'(1));
    tick();
    chk("full_hold_data", out_data, DW'(1));
    out_ready = 1'b1;
    tick();
    chk("rel_out_2", out_data, DW'(2));
    chk("rel_in_ready", DW'(in_ready), DW'(1));
    tick();
    chk("rel_out_3", out_data, DW'(3));
    drive(1'b0, '0, '0);
    tick();
    chk("rel_empty", DW'(out_valid), '0);

    // Flush while FULL, with an input offered in the flush cycle.
    out_ready = 1'b0;
    drive(1'b1, DW'(8'h11), 8'hFF);
    tick();
    drive(1'b1, DW'(8'h22), 8'hFF);
    tick();
    chk("pre_flush_ctrl", DW'(out_ctrl), DW'(8'hFF));
    flush = 1'b1;
    drive(1'b1, DW'(8'h33), 8'hFF);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    chk("flush_out_valid", DW'(out_valid), '0);
    chk("flush_out_ctrl", DW'(out_ctrl), '0);
    chk("flush_in_ready", DW'(in_ready), DW'(1));
    out_ready = 1'b1;
    tick();
    tick();
    chk("flush_no_ghost", DW'(out_valid), '0);

    // Bubble counter saturation after 20 idle cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("bubble_sat", DW'(bubble_cnt), DW'(15));
    repeat (3) tick();
    chk("bubble_hold", DW'(bubble_cnt), DW'(15));

    // Reset while FULL with out_ready high.
    out_ready = 1'b0;
    drive(1'b1, DW'(8'h44), 8'h0F);
    tick();
    drive(1'b1, DW'(8'h55), 8'h0F);
    tick();
    chk("prerst_full", DW'(in_ready), '0);
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("rst_cycle_no_emit", DW'(out_valid), '0);
    tick();
    chk("rstfull_valid", DW'(out_valid), '0);
    chk("rstfull_data", out_data, '0);
    chk("rstfull_ctrl", DW'(out_ctrl), '0);
    rst = 1'b0;
    drive(1'b0, '0, '0);
    tick();
    chk("rstfull_gone", DW'(out_valid), '0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom, $urandom, $urandom, $urandom};
      in_ctrl   = CW'($urandom);
      out_ready = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0;
    flush = 1'b0;
    drive(1'b0, '0, '0);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipe_stage_skid
